// File: rtl/mux_stim_sequencer_pkg.sv
// mux_stim_sequencer_pkg: shared state encoding, widths and ideal mux function
package mux_stim_sequencer_pkg;
    localparam int VEC_IDX_W = 3;
    localparam int ERR_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic exp_mux(input logic x, input logic y, input logic sel);
        return sel ? y : x;
    endfunction
endpackage

// File: rtl/mux_stim_sequencer_hold_counter.sv
// mux_hold_counter: down-counter flagging the last edge of each vector hold
module mux_hold_counter #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam logic [3:0] RELOAD = 4'(HOLD_CYCLES - 1);

    logic [3:0] cnt_q, cnt_d;

    // reload on load or terminal count, otherwise count down while enabled
    always_comb
        cnt_d = load_i ? RELOAD : !en_i ? cnt_q : (cnt_q == 4'd0) ? RELOAD : cnt_q - 4'd1;

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;

    assign tc_o = en_i && (cnt_q == 4'd0);
endmodule

// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer: sweeps all mux input vectors and scores the mux response
module mux_stim_sequencer
    import mux_stim_sequencer_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   z,
    output logic                   x,
    output logic                   y,
    output logic                   sel,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] results,
    output logic [ERR_W-1:0]       err_count,
    output logic                   pass
);
    localparam logic [VEC_IDX_W-1:0] LAST_IDX = VEC_IDX_W'(NUM_VECTORS - 1);

    state_e                 state_q, state_d;
    logic [VEC_IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_VECTORS-1:0] results_q, results_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   load, tc, exp_z;

    mux_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .en_i   (state_q == ST_DRIVE),
        .tc_o   (tc)
    );

    assign exp_z = exp_mux(idx_q[0], idx_q[1], idx_q[2]);

    // state, vector index and scoreboard registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            results_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            results_q <= results_d;
            err_q     <= err_d;
        end

    // next state: start launches a sweep outside DRIVE, abort cancels one inside
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        results_d = results_q;
        err_d     = err_q;
        load      = 1'b0;
        if (state_q != ST_DRIVE) begin
            if (start) begin
                state_d   = ST_DRIVE;
                idx_d     = '0;
                results_d = '0;
                err_d     = '0;
                load      = 1'b1;
            end
        end else if (abort) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            results_d = '0;
            err_d     = '0;
            load      = 1'b1;
        end else if (tc) begin
            results_d[idx_q] = z;
            err_d            = (z != exp_z && err_q != '1) ? err_q + 1'b1 : err_q;
            state_d          = (idx_q == LAST_IDX) ? ST_DONE : ST_DRIVE;
            idx_d            = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // outputs decoded from state; mux inputs only driven during DRIVE
    always_comb begin
        busy = (state_q == ST_DRIVE);
        done = (state_q == ST_DONE);
        pass = done && (err_q == '0);
        x    = busy && idx_q[0];
        y    = busy && idx_q[1];
        sel  = busy && idx_q[2];
    end

    assign results   = results_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_mux_stim_sequencer.sv
// tb_mux_stim_sequencer: randomized sweeps of two sequencers against a vector-level model
module tb_mux_stim_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, abort;
    logic [1:0] start;
    int         mode;
    logic [7:0] zt;
    logic [1:0] x_w, y_w, sel_w, busy_w, done_w, pass_w, z_w;
    logic [7:0] res_w [2];
    logic [3:0] err_w [2];
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    // environment: ideal mux, stuck-at-0, stuck-at-1, or a random per-vector table
    always_comb
        for (int u = 0; u < 2; u++)
            z_w[u] = (mode == 0) ? (sel_w[u] ? y_w[u] : x_w[u]) :
                     (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 :
                     zt[{sel_w[u], y_w[u], x_w[u]}];

    mux_stim_sequencer #(.NUM_VECTORS(8), .HOLD_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .z(z_w[0]),
        .x(x_w[0]), .y(y_w[0]), .sel(sel_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .results(res_w[0]), .err_count(err_w[0]), .pass(pass_w[0]));

    mux_stim_sequencer #(.NUM_VECTORS(8), .HOLD_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .z(z_w[1]),
        .x(x_w[1]), .y(y_w[1]), .sel(sel_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .results(res_w[1]), .err_count(err_w[1]), .pass(pass_w[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic chk_quiet(input int u, input string tag);
        chk({tag, "_busy"}, busy_w[u], 0);
        chk({tag, "_done"}, done_w[u], 0);
        chk({tag, "_pass"}, pass_w[u], 0);
        chk({tag, "_res"},  res_w[u],  0);
        chk({tag, "_err"},  err_w[u],  0);
        chk({tag, "_vec"},  {sel_w[u], y_w[u], x_w[u]}, 0);
    endtask

    task automatic pulse_start(input int u);
        @(posedge clk); #1 start[u] = 1'b1;
        @(posedge clk); #1 start[u] = 1'b0;
    endtask

    // full sweep on instance u with environment m, checked vector by vector
    task automatic sweep(input int u, input int m);
        int h = u ? 3 : 1;
        logic [7:0] want_res = 0;
        int want_err = 0;
        mode = m;
        zt = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            int e  = ((k >> 2) & 1) ? ((k >> 1) & 1) : (k & 1);
            int zk = (m == 0) ? e : (m == 1) ? 0 : (m == 2) ? 1 : int'(zt[k]);
            want_res[k] = zk[0];
            want_err += (zk != e);
        end
        pulse_start(u);
        for (int c = 0; c < 8 * h; c++) begin
            @(negedge clk);
            chk("sw_busy", busy_w[u], 1);
            chk("sw_done", done_w[u], 0);
            chk("sw_vec", {sel_w[u], y_w[u], x_w[u]}, c / h);
            start[u] = (c == 1);
        end
        @(negedge clk);
        chk("end_busy", busy_w[u], 0);
        chk("end_done", done_w[u], 1);
        chk("end_res",  res_w[u], want_res);
        chk("end_err",  err_w[u], want_err);
        chk("end_pass", pass_w[u], want_err == 0);
        chk("end_vec",  {sel_w[u], y_w[u], x_w[u]}, 0);
    endtask

    initial begin
        int a;
        rst_n = 1'b0; start = 2'b00; abort = 1'b0; mode = 0; zt = 8'h00;
        #12;
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");
        rst_n = 1'b1;
        sweep(0, 0);
        chk("real_res", res_w[0], 8'hCA);
        sweep(0, 1);
        chk("tie0_res", res_w[0], 8'h00);
        sweep(0, 2);
        chk("tie1_res", res_w[0], 8'hFF);
        sweep(1, 0);
        chk("hold3_res", res_w[1], 8'hCA);
        // abort on the 4th busy cycle, then a random one
        for (int r = 0; r < 2; r++) begin
            a = r ? $urandom_range(1, 7) : 4;
            mode = 0;
            pulse_start(0);
            for (int c = 1; c < a; c++) @(negedge clk);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk_quiet(0, "abort");
            sweep(0, 0);
        end
        // asynchronous reset mid-sweep
        pulse_start(0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_quiet(0, "arst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_quiet(0, "arst_hold");
        for (int r = 0; r < 8; r++) sweep($urandom_range(0, 1), $urandom_range(0, 3));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
